// File: rtl/alu_op_sequencer_if.sv
// ALU-side bus between alu_op_sequencer (master) and the combinational 4-bit ALU (slave).
interface alu_op_sequencer_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_c1;
    logic             alu_c0;
    logic [WIDTH-1:0] alu_y;
    logic [WIDTH-1:0] alu_z;

    modport master (
        output alu_a, alu_b, alu_c1, alu_c0,
        input  alu_y, alu_z
    );

    modport slave (
        input  alu_a, alu_b, alu_c1, alu_c0,
        output alu_y, alu_z
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sweeps the ALU select through 00..11 on one start pulse and captures y/z per operation.
// Optional abort input/aborted output enabled by defining ALU_SEQ_ABORT_EN.
module alu_op_sequencer #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    alu_op_sequencer_if.master   alu,
    output logic [4*WIDTH-1:0]   res_y,
    output logic [4*WIDTH-1:0]   res_z,
    output logic                 busy,
    output logic                 done
`ifdef ALU_SEQ_ABORT_EN
    ,
    input  logic                 abort,
    output logic                 aborted
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       sel;
    logic [3:0]       cnt;
    logic             abort_hit;

`ifdef ALU_SEQ_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    assign alu.alu_a  = a_q;
    assign alu.alu_b  = b_q;
    assign alu.alu_c1 = sel[1];
    assign alu.alu_c0 = sel[0];

    // Capture happens on the last settle cycle, so even with SETTLE=0 the ALU has a full period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            sel   <= 2'd0;
            cnt   <= 4'd0;
            res_y <= '0;
            res_z <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef ALU_SEQ_ABORT_EN
            aborted <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef ALU_SEQ_ABORT_EN
            aborted <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= op_a;
                        b_q   <= op_b;
                        sel   <= 2'd0;
                        cnt   <= 4'd0;
                        res_y <= '0;
                        res_z <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (abort_hit) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        sel   <= 2'd0;
                        cnt   <= 4'd0;
`ifdef ALU_SEQ_ABORT_EN
                        aborted <= 1'b1;
`endif
                    end else if (cnt < SETTLE_CNT) begin
                        cnt <= cnt + 4'd1;
                    end else begin
                        cnt <= 4'd0;
                        res_y[int'(sel)*WIDTH +: WIDTH] <= alu.alu_y;
                        res_z[int'(sel)*WIDTH +: WIDTH] <= alu.alu_z;
                        if (sel == 2'd3) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            sel <= sel + 2'd1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    sel   <= 2'd0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    sel   <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: one DUT with SETTLE=1, one with SETTLE=0.
module tb_alu_op_sequencer;

    localparam int WIDTH = 4;

    typedef struct packed {
        logic [15:0] y;
        logic [15:0] z;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start1;
    logic        start0;
    logic [3:0]  op_a;
    logic [3:0]  op_b;
    logic [15:0] res_y1, res_z1, res_y0, res_z0;
    logic        busy1, done1, busy0, done0;
`ifdef ALU_SEQ_ABORT_EN
    logic        abort1;
    logic        aborted1;
    logic        aborted0;
`endif

    int errors   = 0;
    int checks   = 0;
    int done_cnt1 = 0;
    int done_cnt0 = 0;
    exp_t q1[$];
    exp_t q0[$];
    exp_t e1;
    exp_t e0;

    always #5 clk = ~clk;

    alu_op_sequencer_if #(.WIDTH(WIDTH)) bus1 ();
    alu_op_sequencer_if #(.WIDTH(WIDTH)) bus0 ();

    // ALU stub: y = a + select, z = b
    assign bus1.alu_y = bus1.alu_a + {2'b00, bus1.alu_c1, bus1.alu_c0};
    assign bus1.alu_z = bus1.alu_b;
    assign bus0.alu_y = bus0.alu_a + {2'b00, bus0.alu_c1, bus0.alu_c0};
    assign bus0.alu_z = bus0.alu_b;

    alu_op_sequencer #(.WIDTH(WIDTH), .SETTLE(1)) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .op_a  (op_a),
        .op_b  (op_b),
        .alu   (bus1),
        .res_y (res_y1),
        .res_z (res_z1),
        .busy  (busy1),
        .done  (done1)
`ifdef ALU_SEQ_ABORT_EN
        ,
        .abort   (abort1),
        .aborted (aborted1)
`endif
    );

    alu_op_sequencer #(.WIDTH(WIDTH), .SETTLE(0)) u0 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start0),
        .op_a  (op_a),
        .op_b  (op_b),
        .alu   (bus0),
        .res_y (res_y0),
        .res_z (res_z0),
        .busy  (busy0),
        .done  (done0)
`ifdef ALU_SEQ_ABORT_EN
        ,
        .abort   (1'b0),
        .aborted (aborted0)
`endif
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Starts a sweep on the selected DUT; leaves the bench at the negedge after the accepting edge.
    task automatic apply_stimulus(input bit which, input logic [3:0] a, input logic [3:0] b,
                                  input logic [15:0] exp_y, input logic [15:0] exp_z,
                                  input bit expect_done);
        exp_t e;
        @(negedge clk);
        op_a = a;
        op_b = b;
        if (which) start1 = 1'b1;
        else       start0 = 1'b1;
        if (expect_done) begin
            e.y = exp_y;
            e.z = exp_z;
            if (which) q1.push_back(e);
            else       q0.push_back(e);
        end
        @(negedge clk);
        start1 = 1'b0;
        start0 = 1'b0;
    endtask

    task automatic wait_done(input bit which, input int budget);
        int n = 0;
        while (((which ? done1 : done0) !== 1'b1) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_output("done_within_budget", {31'd0, (which ? done1 : done0)}, 32'd1);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (done1 === 1'b1) begin
            done_cnt1++;
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL u1_unexpected_done: got done=1 expected no pending sweep");
            end else begin
                e1 = q1.pop_front();
                check_output("u1_res_y", {16'd0, res_y1}, {16'd0, e1.y});
                check_output("u1_res_z", {16'd0, res_z1}, {16'd0, e1.z});
            end
        end
    end

    always @(negedge clk) begin
        if (done0 === 1'b1) begin
            done_cnt0++;
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL u0_unexpected_done: got done=1 expected no pending sweep");
            end else begin
                e0 = q0.pop_front();
                check_output("u0_res_y", {16'd0, res_y0}, {16'd0, e0.y});
                check_output("u0_res_z", {16'd0, res_z0}, {16'd0, e0.z});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int d0;
        int n;
        rst_n  = 1'b0;
        start1 = 1'b0;
        start0 = 1'b0;
        op_a   = 4'h0;
        op_b   = 4'h0;
`ifdef ALU_SEQ_ABORT_EN
        abort1 = 1'b0;
`endif
        @(negedge clk);
        check_output("rst_busy", {31'd0, busy1}, 32'd0);
        check_output("rst_done", {31'd0, done1}, 32'd0);
        check_output("rst_res_y", {16'd0, res_y1}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_output("idle_busy", {31'd0, busy1}, 32'd0);

        // Basic sweep, SETTLE=1
        apply_stimulus(1'b1, 4'b1101, 4'b1110, 16'h0FED, 16'hEEEE, 1'b1);
        check_output("basic_busy", {31'd0, busy1}, 32'd1);
        check_output("basic_alu_a", {28'd0, bus1.alu_a}, 32'hD);
        check_output("basic_alu_b", {28'd0, bus1.alu_b}, 32'hE);
        for (int i = 0; i < 8; i++) begin
            check_output($sformatf("basic_sel_%0d", i), {30'd0, bus1.alu_c1, bus1.alu_c0}, 32'(i / 2));
            @(negedge clk);
        end
        check_output("basic_done", {31'd0, done1}, 32'd1);
        check_output("basic_busy_done", {31'd0, busy1}, 32'd1);
        @(negedge clk);
        check_output("basic_busy_after", {31'd0, busy1}, 32'd0);
        check_output("basic_done_after", {31'd0, done1}, 32'd0);
        check_output("basic_sel_after", {30'd0, bus1.alu_c1, bus1.alu_c0}, 32'd0);
        check_output("basic_alu_a_hold", {28'd0, bus1.alu_a}, 32'hD);
        check_output("basic_res_hold", {16'd0, res_y1}, 32'h0FED);

        // Asynchronous reset mid-cycle
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_output("async_alu_a", {28'd0, bus1.alu_a}, 32'd0);
        check_output("async_res_y", {16'd0, res_y1}, 32'd0);
        check_output("async_res_z", {16'd0, res_z1}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_output("async_idle_busy", {31'd0, busy1}, 32'd0);

        // SETTLE=0 latency
        apply_stimulus(1'b0, 4'b1101, 4'b1110, 16'h0FED, 16'hEEEE, 1'b1);
        n = 0;
        while (done0 !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_output("s0_latency", 32'(n), 32'd4);
        @(negedge clk);
        check_output("s0_busy_after", {31'd0, busy0}, 32'd0);

        // start and op_a changes during RUN are ignored
        d0 = done_cnt1;
        apply_stimulus(1'b1, 4'b1101, 4'b1110, 16'h0FED, 16'hEEEE, 1'b1);
        repeat (2) @(negedge clk);
        start1 = 1'b1;
        op_a   = 4'b0000;
        repeat (3) @(negedge clk);
        start1 = 1'b0;
        repeat (10) @(negedge clk);
        check_output("ignore_done_count", 32'(done_cnt1 - d0), 32'd1);
        check_output("ignore_alu_a", {28'd0, bus1.alu_a}, 32'hD);

        // Reset mid-RUN after two captures
        d0 = done_cnt1;
        apply_stimulus(1'b1, 4'b1101, 4'b1110, 16'h0, 16'h0, 1'b0);
        repeat (4) @(negedge clk);
        check_output("partial_res_y", {16'd0, res_y1}, 32'h00ED);
        #2 rst_n = 1'b0;
        #1;
        check_output("midrun_res_y", {16'd0, res_y1}, 32'd0);
        check_output("midrun_busy", {31'd0, busy1}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check_output("midrun_no_done", 32'(done_cnt1 - d0), 32'd0);
        apply_stimulus(1'b1, 4'b1101, 4'b1110, 16'h0FED, 16'hEEEE, 1'b1);
        wait_done(1'b1, 20);

`ifdef ALU_SEQ_ABORT_EN
        // Abort sampled at E5
        d0 = done_cnt1;
        apply_stimulus(1'b1, 4'b1101, 4'b1110, 16'h0, 16'h0, 1'b0);
        repeat (4) @(negedge clk);
        abort1 = 1'b1;
        @(negedge clk);
        abort1 = 1'b0;
        check_output("abort_pulse", {31'd0, aborted1}, 32'd1);
        check_output("abort_busy", {31'd0, busy1}, 32'd0);
        check_output("abort_res_y", {16'd0, res_y1}, 32'h00ED);
        check_output("abort_sel", {30'd0, bus1.alu_c1, bus1.alu_c0}, 32'd0);
        @(negedge clk);
        check_output("abort_pulse_end", {31'd0, aborted1}, 32'd0);
        repeat (10) @(negedge clk);
        check_output("abort_no_done", 32'(done_cnt1 - d0), 32'd0);
        check_output("abort_u0_quiet", {31'd0, aborted0}, 32'd0);
        apply_stimulus(1'b1, 4'b1101, 4'b1110, 16'h0FED, 16'hEEEE, 1'b1);
        wait_done(1'b1, 20);
`endif

        repeat (3) @(negedge clk);
        check_output("q1_drained", 32'(q1.size()), 32'd0);
        check_output("q0_drained", 32'(q0.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Upstream driver and result collector for the 4-bit ALU with 2-bit select (c1,c0) and two 4-bit outputs (y,z). On one start pulse it latches an operand pair, sweeps the select through all four operations 00,01,10,11, waits a programmable settle time on each, and captures y/z per operation into packed result registers. Sits between the lab's control/test logic and the combinational ALU, replacing hand-toggled select lines with a clocked sweep.

Parameters:
WIDTH, 4, operand and ALU output width
SETTLE, 1, extra clock cycles the select is held before capture (legal range 0..15)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a sweep; sampled only in IDLE
op_a  input  WIDTH  operand A, latched when start is accepted
op_b  input  WIDTH  operand B, latched when start is accepted
alu_a  output  WIDTH  operand A to ALU (registered)
alu_b  output  WIDTH  operand B to ALU (registered)
alu_c1  output  1  ALU select MSB
alu_c0  output  1  ALU select LSB
alu_y  input  WIDTH  ALU output y (combinational from alu_a/alu_b/select)
alu_z  input  WIDTH  ALU output z
res_y  output  4*WIDTH  captured y; slot k = bits [k*WIDTH +: WIDTH] for select k={c1,c0}
res_z  output  4*WIDTH  captured z, same packing
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse when all four results valid

Behaviour:
- One clock domain. rst_n asserted clears all registers, immediately and asynchronously, regardless of clk. Reset values: state=IDLE, alu_a=0, alu_b=0, alu_c1=0, alu_c0=0, res_y=0, res_z=0, busy=0, done=0, internal sel=0, cnt=0.
- States: IDLE, RUN, DONE.
- IDLE: on an edge with start=1: alu_a<=op_a, alu_b<=op_b, sel<=0, cnt<=0, res_y<=0, res_z<=0, state<=RUN. start=0: hold all.
- RUN: {alu_c1,alu_c0}=sel at all times (registered). Each edge: if cnt<SETTLE, cnt<=cnt+1. If cnt==SETTLE, capture alu_y/alu_z into slot sel and set cnt<=0. Then, if sel==3, state<=DONE; otherwise sel<=sel+1.
- Each operation occupies SETTLE+1 cycles. With SETTLE=0, the ALU still gets one full clock period after the select changes before capture.
- Total RUN time is 4*(SETTLE+1) cycles.
- DONE: done=1 for exactly one cycle. Next edge: state<=IDLE, busy<=0, sel<=0 (select returns to 00). alu_a/alu_b hold.
- start while busy is ignored, not queued. start held high continuously re-triggers on the first IDLE edge, so back-to-back sweeps have one IDLE cycle between DONE and the next RUN.
- op_a/op_b changes after acceptance have no effect until the next accepted start.
- Results are held stable from done until the next accepted start clears them.
- Reset mid-RUN: outputs return to reset values asynchronously, no done pulse, partial results discarded.
- cnt width is 4 bits; sel is 2 bits and never wraps (exit at sel==3).

Optional Feature:
ALU_SEQ_ABORT_EN
- Defined: adds input abort (1 bit) and output aborted (1 bit, reset 0).
  - abort=1 at an edge in RUN: state<=IDLE, busy<=0, sel<=0, no capture that edge, no done.
  - aborted pulses high for exactly one cycle.
  - Already-captured slots keep their values; uncaptured slots stay 0.
  - abort in IDLE or DONE has no effect; DONE completes normally.
  - abort and start together in IDLE: start wins.
- Not defined: ports abort/aborted absent; behaviour exactly as above.

Test Plan:
- Bench ALU stub: y=alu_a+{c1,c0} mod 16, z=alu_b.
- Reset: rst_n=0 asserted mid-cycle -> all outputs 0 before next clk edge; release with start=0 -> stays IDLE, busy=0.
- Basic sweep, SETTLE=1: op_a=4'b1101, op_b=4'b1110, start pulse at edge E0.
  - busy=1 after E0.
  - select 00/01/10/11 during E0-E2, E2-E4, E4-E6, E6-E8.
  - done=1 between E8 and E9.
  - res_y=16'h0FED, res_z=16'hEEEE.
  - busy=0 after E9.
- SETTLE=0: same operands -> done one cycle after the 4th edge following start acceptance; same res_y/res_z values.
- start asserted during RUN and op_a changed to 4'b0000 mid-sweep -> ignored; results still 16'h0FED; exactly one done pulse.
- Reset mid-RUN after two captures -> res_y=0 immediately; no done; new start then completes normally with correct results.
- With ALU_SEQ_ABORT_EN, SETTLE=1: abort at E5 -> aborted pulse one cycle, busy=0, res_y=16'h00ED, no done; following start completes with 16'h0FED.
